// File: rtl/vertex_project.sv
// vertex_project: trivial frustum reject, perspective divide and viewport
// mapping of one float32 clip-space vertex to integer pixel x/y + NDC depth.
// Ports: clock; reset (sync, active-low); start/ready accept handshake;
// cx/cy/cz/cw float32 vertex in; sx/sy pixel coords, depth float32 NDC z,
// clipped reject flag, done one-cycle result pulse.
module vertex_project #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int X_BITS  = 9,
    parameter int Y_BITS  = 8,
    parameter int DIV_LAT = 6,
    parameter int MUL_LAT = 5,
    parameter int ADD_LAT = 7,
    parameter int CVT_LAT = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       cx,
    input  logic [31:0]       cy,
    input  logic [31:0]       cz,
    input  logic [31:0]       cw,
    output logic              ready,
    output logic [X_BITS-1:0] sx,
    output logic [Y_BITS-1:0] sy,
    output logic [31:0]       depth,
    output logic              clipped,
    output logic              done
);

    // Float operators: round-to-nearest-even, denormals flush to zero,
    // no NaN handling. Each result is captured on the last cycle of the
    // latency window of the state that owns the operator.
    function automatic logic [31:0] f_pack(input logic s, input int e,
                                           input logic [22:0] m,
                                           input logic g, input logic st);
        logic [31:0] r;
        if (e <= 0) return {s, 31'd0};
        if (e >= 255) return {s, 8'hff, 23'd0};
        r = {s, e[7:0], m};
        // carry out of the fraction bumps the exponent for free
        if (g && (st || m[0])) r = r + 32'd1;
        return r;
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [47:0] p;
        logic        s;
        int          e;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) return f_pack(s, e + 1, p[46:24], p[23], |p[22:0]);
        return f_pack(s, e, p[45:23], p[22], |p[21:0]);
    endfunction

    function automatic logic [31:0] f_recip(input logic [31:0] w);
        logic [49:0] n;
        logic [49:0] den;
        logic [24:0] q;
        int          e;
        e = int'(w[30:23]);
        if (w[22:0] == 23'd0) return f_pack(w[31], 254 - e, 23'd0, 1'b0, 1'b0);
        // 2^49 / m lands in (2^25, 2^26): bit 25 is the hidden one
        n   = 50'd1 << 49;
        den = {26'd0, 1'b1, w[22:0]};
        q   = 25'(n / den);
        return f_pack(w[31], 253 - e, q[24:2], q[1],
                      q[0] | ((n % den) != 50'd0));
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [31:0] x;
        logic [31:0] y;
        logic [27:0] mx;
        logic [27:0] my;
        logic [27:0] mask;
        int          d;
        int          e;
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        if (y[30:23] == 8'd0) return x;
        e  = int'(x[30:23]);
        d  = e - int'(y[30:23]);
        // hidden bit at 26, three guard/round/sticky bits below the fraction
        mx = {2'b01, x[22:0], 3'b000};
        my = {2'b01, y[22:0], 3'b000};
        if (d > 26) begin
            my = 28'd1;
        end else if (d > 0) begin
            mask = (28'd1 << d) - 28'd1;
            my   = (my >> d) | {27'd0, |(my & mask)};
        end
        if (x[31] == y[31]) mx = mx + my;
        else mx = mx - my;
        if (mx == 28'd0) return 32'd0;
        if (mx[27]) begin
            mx = (mx >> 1) | {27'd0, mx[0]};
            e  = e + 1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!mx[26]) begin
                mx = mx << 1;
                e  = e - 1;
            end
        end
        return f_pack(x[31], e, mx[25:3], mx[2], |mx[1:0]);
    endfunction

    function automatic int f_to_int(input logic [31:0] a);
        logic [31:0] mag;
        int          e;
        e = int'(a[30:23]) - 127;
        if (e < 0) return 0;
        if (e > 30) mag = 32'h7fff_ffff;
        else if (e >= 23) mag = {8'd0, 1'b1, a[22:0]} << (e - 23);
        else mag = {8'd0, 1'b1, a[22:0]} >> (23 - e);
        return a[31] ? -int'(mag) : int'(mag);
    endfunction

    // float32 of n/2, elaborated once for the viewport scale
    function automatic logic [31:0] f_half(input int n);
        logic [22:0] m;
        int          p;
        p = 0;
        for (int i = 0; i < 24; i++) begin
            if (n >= (1 << i)) p = i;
        end
        m = 23'(n << (23 - p));
        return {1'b0, 8'(126 + p), m};
    endfunction

    localparam logic [31:0] ONE    = 32'h3f80_0000;
    localparam logic [31:0] HALF_W = f_half(WIDTH);
    localparam logic [31:0] HALF_H = f_half(HEIGHT);

    typedef enum logic [2:0] {
        S_WAIT, S_CLIP, S_RECIP, S_SCALE,
        S_OFFSET, S_VIEWPORT, S_CONVERT, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       vx_q, vx_d, vy_q, vy_d, vz_q, vz_d, vw_q, vw_d;
    logic [31:0]       a_q, a_d, b_q, b_d, nz_q, nz_d;
    logic [X_BITS-1:0] sx_q, sx_d;
    logic [Y_BITS-1:0] sy_q, sy_d;
    logic [31:0]       depth_q, depth_d;
    logic              clipped_q, clipped_d;
    logic              clip;
    logic              last;
    int                lat;
    int                ix;
    int                iy;

    assign clip = vw_q[31] || (vw_q[30:0] == 31'd0) ||
                  (vx_q[30:0] > vw_q[30:0]) ||
                  (vy_q[30:0] > vw_q[30:0]) ||
                  (vz_q[30:0] > vw_q[30:0]);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            vx_q      <= '0;
            vy_q      <= '0;
            vz_q      <= '0;
            vw_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            nz_q      <= '0;
            sx_q      <= '0;
            sy_q      <= '0;
            depth_q   <= '0;
            clipped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vx_q      <= vx_d;
            vy_q      <= vy_d;
            vz_q      <= vz_d;
            vw_q      <= vw_d;
            a_q       <= a_d;
            b_q       <= b_d;
            nz_q      <= nz_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            depth_q   <= depth_d;
            clipped_q <= clipped_d;
        end
    end

    always_comb begin
        lat = 1;
        unique case (state_q)
            S_RECIP:             lat = DIV_LAT;
            S_SCALE, S_VIEWPORT: lat = MUL_LAT;
            S_OFFSET:            lat = ADD_LAT;
            S_CONVERT:           lat = CVT_LAT;
            default:             lat = 1;
        endcase
        last    = (int'(cnt_q) == lat - 1);
        state_d = state_q;
        unique case (state_q)
            S_WAIT:     if (start) state_d = S_CLIP;
            S_CLIP:     state_d = clip ? S_DONE : S_RECIP;
            S_RECIP:    if (last) state_d = S_SCALE;
            S_SCALE:    if (last) state_d = S_OFFSET;
            S_OFFSET:   if (last) state_d = S_VIEWPORT;
            S_VIEWPORT: if (last) state_d = S_CONVERT;
            S_CONVERT:  if (last) state_d = S_DONE;
            default:    state_d = S_WAIT;
        endcase
        cnt_d = (state_d != state_q) ? 8'd0 : cnt_q + 8'd1;
    end

    always_comb begin
        vx_d      = vx_q;
        vy_d      = vy_q;
        vz_d      = vz_q;
        vw_d      = vw_q;
        a_d       = a_q;
        b_d       = b_q;
        nz_d      = nz_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        depth_d   = depth_q;
        clipped_d = clipped_q;
        ready     = 1'b0;
        done      = 1'b0;
        ix        = f_to_int(a_q);
        iy        = f_to_int(b_q);
        unique case (state_q)
            S_WAIT: begin
                ready = 1'b1;
                if (start) begin
                    vx_d = cx;
                    vy_d = cy;
                    vz_d = cz;
                    vw_d = cw;
                end
            end
            S_CLIP: begin
                if (clip) begin
                    sx_d      = '0;
                    sy_d      = '0;
                    depth_d   = '0;
                    clipped_d = 1'b1;
                end
            end
            S_RECIP: if (last) a_d = f_recip(vw_q);
            S_SCALE: begin
                if (last) begin
                    a_d  = f_mul(vx_q, a_q);
                    b_d  = f_mul(vy_q, a_q);
                    nz_d = f_mul(vz_q, a_q);
                end
            end
            S_OFFSET: begin
                // screen y grows downward, so y maps through 1 - ny
                if (last) begin
                    a_d = f_add(a_q, ONE);
                    b_d = f_add(ONE, {~b_q[31], b_q[30:0]});
                end
            end
            S_VIEWPORT: begin
                if (last) begin
                    a_d = f_mul(a_q, HALF_W);
                    b_d = f_mul(b_q, HALF_H);
                end
            end
            S_CONVERT: begin
                // results become visible together, in the done cycle
                if (last) begin
                    if (ix < 0) sx_d = '0;
                    else if (ix > WIDTH - 1) sx_d = X_BITS'(WIDTH - 1);
                    else sx_d = ix[X_BITS-1:0];
                    if (iy < 0) sy_d = '0;
                    else if (iy > HEIGHT - 1) sy_d = Y_BITS'(HEIGHT - 1);
                    else sy_d = iy[Y_BITS-1:0];
                    depth_d   = nz_q;
                    clipped_d = 1'b0;
                end
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign sx      = sx_q;
    assign sy      = sy_q;
    assign depth   = depth_q;
    assign clipped = clipped_q;

endmodule

// File: tb/tb_vertex_project.sv
// tb_vertex_project: random and directed vertices through vertex_project,
// checked by a scoreboard against a float32 reference model.
module tb_vertex_project;

    localparam int WIDTH   = 320;
    localparam int HEIGHT  = 240;
    localparam int X_BITS  = 9;
    localparam int Y_BITS  = 8;
    localparam int DIV_LAT = 6;
    localparam int MUL_LAT = 5;
    localparam int ADD_LAT = 7;
    localparam int CVT_LAT = 6;
    localparam int LAT     = 2 + DIV_LAT + 2 * MUL_LAT + ADD_LAT + CVT_LAT;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       cx = '0;
    logic [31:0]       cy = '0;
    logic [31:0]       cz = '0;
    logic [31:0]       cw = '0;
    logic              ready;
    logic [X_BITS-1:0] sx;
    logic [Y_BITS-1:0] sy;
    logic [31:0]       depth;
    logic              clipped;
    logic              done;

    typedef struct {
        logic [31:0] sx;
        logic [31:0] sy;
        logic [31:0] depth;
        logic        clipped;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    vertex_project #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_BITS(X_BITS), .Y_BITS(Y_BITS),
        .DIV_LAT(DIV_LAT), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT),
        .CVT_LAT(CVT_LAT)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .cx(cx), .cy(cy), .cz(cz), .cw(cw),
        .ready(ready), .sx(sx), .sy(sy), .depth(depth),
        .clipped(clipped), .done(done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not end, got cycle %0d, need end", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) d = {f[31], 63'd0};
        else d = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // double -> float32, round to nearest even
    function automatic logic [31:0] rnd(input real r);
        logic [63:0] d;
        logic [31:0] f;
        int          e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = int'(d[62:52]) - 896;
        f = {d[63], e[7:0], d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) f = f + 32'd1;
        return f;
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic [31:0] z, input logic [31:0] w);
        exp_t        e;
        logic [31:0] inv;
        logic [31:0] fx;
        logic [31:0] fy;
        e.acc     = 0;
        e.clipped = w[31] || (w[30:0] == 31'd0) || (x[30:0] > w[30:0]) ||
                    (y[30:0] > w[30:0]) || (z[30:0] > w[30:0]);
        if (e.clipped) begin
            e.sx    = 0;
            e.sy    = 0;
            e.depth = 0;
            e.lat   = 2;
            return e;
        end
        inv     = rnd(1.0 / f2r(w));
        e.depth = rnd(f2r(z) * f2r(inv));
        fx = rnd(f2r(rnd(f2r(rnd(f2r(x) * f2r(inv))) + 1.0)) * (WIDTH / 2.0));
        fy = rnd(f2r(rnd(1.0 - f2r(rnd(f2r(y) * f2r(inv))))) * (HEIGHT / 2.0));
        e.sx  = 32'(clampi($rtoi(f2r(fx)), WIDTH - 1));
        e.sy  = 32'(clampi($rtoi(f2r(fy)), HEIGHT - 1));
        e.lat = LAT;
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (reset && done) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_done: got done=1, expected no result");
            end else begin
                e = sb.pop_front();
                chk("sx", 32'(sx), e.sx);
                chk("sy", 32'(sy), e.sy);
                chk("depth", depth, e.depth);
                chk("clipped", 32'(clipped), 32'(e.clipped));
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [31:0] w);
        exp_t e;
        int   n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
        if (ready !== 1'b1) return;
        chk("one_in_flight", 32'(sb.size()), 32'd0);
        cx    = x;
        cy    = y;
        cz    = z;
        cw    = w;
        start = 1'b1;
        e     = model(x, y, z, w);
        e.acc = cyc + 1;
        sb.push_back(e);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sx"}, 32'(sx), 32'd0);
        chk({tag, "_sy"}, 32'(sy), 32'd0);
        chk({tag, "_depth"}, depth, 32'd0);
        chk({tag, "_clipped"}, 32'(clipped), 32'd0);
    endtask

    function automatic logic [31:0] rand_w();
        int k;
        k = int'($urandom_range(0, 15));
        if (k == 0) return 32'h0000_0000;
        if (k == 1) return 32'h8000_0000;
        return {k == 2, 8'(125 + $urandom_range(0, 4)), 23'($urandom)};
    endfunction

    function automatic logic [31:0] rand_c(input logic [31:0] w);
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0) return 32'd0;
        if (k == 1) return {1'($urandom), w[30:0]};
        return {1'($urandom), 8'(int'(w[30:23]) - int'($urandom_range(0, 4))),
                23'($urandom)};
    endfunction

    logic [31:0] vec [10][4] = '{
        '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3f80_0000},
        '{32'h4000_0000, 32'hc000_0000, 32'h3f80_0000, 32'h4080_0000},
        '{32'h3f80_0000, 32'h3f80_0000, 32'h0000_0000, 32'h3f80_0000},
        '{32'hbf80_0000, 32'hbf80_0000, 32'h0000_0000, 32'h3f80_0000},
        '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hbf80_0000},
        '{32'h4000_0000, 32'h0000_0000, 32'h0000_0000, 32'h3f80_0000},
        '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000},
        '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h8000_0000},
        '{32'h3f80_0000, 32'h0000_0000, 32'h0000_0000, 32'h3f80_0000},
        '{32'h3f00_0000, 32'hbe80_0000, 32'hbf40_0000, 32'h4040_0000}
    };

    initial begin
        logic [31:0] w;
        repeat (3) @(negedge clock);
        chk_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 10; i++) begin
            issue(vec[i][0], vec[i][1], vec[i][2], vec[i][3]);
        end
        wait_idle();

        // start pulsed at cycle 10 of a vertex must be ignored
        issue(32'h4000_0000, 32'hc000_0000, 32'h3f80_0000, 32'h4080_0000);
        repeat (9) @(negedge clock);
        cx    = 32'h3f80_0000;
        cy    = 32'h3f80_0000;
        cz    = 32'h0000_0000;
        cw    = 32'hbf80_0000;
        start = 1'b1;
        chk("ready_busy", 32'(ready), 32'd0);
        @(negedge clock);
        start = 1'b0;
        issue(32'h3f80_0000, 32'h3f80_0000, 32'h0000_0000, 32'h3f80_0000);
        wait_idle();

        // reset at cycle 15 abandons the vertex without a done pulse
        issue(32'h3f00_0000, 32'h3f00_0000, 32'h3f00_0000, 32'h3f80_0000);
        repeat (14) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        @(negedge clock);
        chk_reset_outputs("abort");
        reset = 1'b1;
        repeat (40) @(negedge clock);
        issue(32'h4000_0000, 32'hc000_0000, 32'h3f80_0000, 32'h4080_0000);
        wait_idle();

        for (int i = 0; i < 60; i++) begin
            w = rand_w();
            issue(rand_c(w), rand_c(w), rand_c(w), w);
        end
        wait_idle();
        repeat (3) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vertex_project.md
Name: vertex_project

Overview:
- Consumes one clip-space vertex (x, y, z, w as IEEE-754 single floats), produced downstream of the MVP transform stage (column 0 of its output matrix).
- Performs trivial frustum rejection, perspective divide and viewport mapping, and emits integer pixel coordinates plus NDC depth to the rasteriser.
- Processes one vertex at a time through an FSM sequencing fixed-latency float IP cores (float_div, float_mult, float_add, float_to_int).

Parameters:
WIDTH, 320, screen width in pixels
HEIGHT, 240, screen height in pixels
X_BITS, 9, width of sx output
Y_BITS, 8, width of sy output
DIV_LAT, 6, float_div latency in cycles
MUL_LAT, 5, float_mult latency in cycles
ADD_LAT, 7, float_add latency in cycles
CVT_LAT, 6, float_to_int latency in cycles

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (0 = reset)
start  in  1  request to accept the vertex on cx/cy/cz/cw
cx, cy, cz, cw  in  32 each  clip-space vertex, float32
ready  out  1  high in S_WAIT only; start is accepted only when ready=1
sx  out  X_BITS  screen x, 0..WIDTH-1
sy  out  Y_BITS  screen y, 0..HEIGHT-1, row 0 at top
depth  out  32  NDC z (float32)
clipped  out  1  vertex rejected; sx/sy/depth are 0
done  out  1  single-cycle pulse when results are valid

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to S_WAIT.
  - sx=0, sy=0, depth=0, clipped=0, done=0, ready=1 after the edge.
  - Float IP aclr is driven by ~reset.
  - Reset mid-operation abandons the vertex; no done pulse is produced for it.
- Accept: start=1 while in S_WAIT latches cx..cw into internal registers at that edge (T0). start is ignored in every other state.
- States, with a shared latency counter cleared on each state entry:
  - S_WAIT -> S_CLIP on accept.
  - S_CLIP (1 cycle):
    - clipped if cw sign=1, or cw magnitude bits [30:0]==0, or |c|>|cw| for any c in {cx, cy, cz}.
    - Magnitude comparison is an unsigned compare of bits [30:0]; inputs are assumed non-NaN.
    - Clipped -> S_DONE, with outputs zeroed and clipped=1. Otherwise -> S_RECIP.
  - S_RECIP (DIV_LAT cycles): inv_w = 1.0 / cw.
  - S_SCALE (MUL_LAT cycles): nx = cx*inv_w, ny = cy*inv_w, nz = cz*inv_w, using three multipliers in parallel. nz is registered as depth.
  - S_OFFSET (ADD_LAT cycles): ax = nx + 1.0, ay = 1.0 - ny.
  - S_VIEWPORT (MUL_LAT cycles): fx = ax*(WIDTH/2.0), fy = ay*(HEIGHT/2.0). Constants are float32 computed at elaboration.
  - S_CONVERT (CVT_LAT cycles):
    - Truncating float-to-int conversion.
    - Result clamped to [0, WIDTH-1] and [0, HEIGHT-1]; e.g. 320 -> 319, negative -> 0.
    - Result registered into sx/sy; clipped=0.
  - S_DONE (1 cycle): done=1, then -> S_WAIT.
- Latency from the accept edge to the done cycle:
  - Unclipped: 2+DIV_LAT+2*MUL_LAT+ADD_LAT+CVT_LAT cycles (31 at defaults).
  - Clipped: 2 cycles.
- Outputs hold their values from the done cycle until the next done or reset.
- start held high continuously re-accepts on the S_WAIT cycle following each done.

Test Plan:
- (0,0,0,1.0) i.e. 0,0,0,3f800000 -> done exactly 31 cycles after accept; sx=160, sy=120, depth=0, clipped=0.
- (2.0,-2.0,1.0,4.0) -> ndc (0.5,-0.5,0.25); sx=240, sy=180, depth=3e800000, clipped=0.
- (1.0,1.0,0,1.0) -> sx=319 (clamped from 320), sy=0. (-1.0,-1.0,0,1.0) -> sx=0, sy=239 (clamped from 240).
- Clip cases:
  - cw=bf800000 (-1.0) -> clipped=1, sx=sy=depth=0, done 2 cycles after accept.
  - cx=2.0, cw=1.0 -> clipped.
  - cw=+0 or -0 -> clipped.
  - |cx|==|cw| (1.0,0,0,1.0) -> not clipped, sx=319.
- Pulse start again mid-computation (cycle 10) with different data -> ignored; ready=0; first result unchanged; second vertex accepted only after done.
- Assert reset=0 at cycle 15 of a vertex -> no done pulse, outputs 0, ready=1 the next cycle; a fresh vertex then completes in 31 cycles with correct values.
